i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Deserialises an I2S stereo stream (bit clock, word select, serial data) into parallel words, one per channel slot. It is the receive end of the serial data path and is fed by the pin-level I2S lines. All inputs are sampled in the system clock domain. Completed words are presented through a ready/valid holding register, with a sticky overflow flag for words dropped under backpressure.

## Interface
- WIDTH, 16: output word width in bits.
- SYNC_STAGES, 2: synchroniser depth for `sck`, `ws` and `sd` (≥2).
- clk  input  1  system clock. Frequency ≥ 4× `sck`; `sck` is high ≥2 and low ≥2 `clk` periods.
- rst  input  1  reset, asynchronous, active-high.
- sck  input  1  I2S bit clock (asynchronous to `clk`).
- ws  input  1  word select: 0 = left, 1 = right.
- sd  input  1  serial data, MSB first.
- data  output  WIDTH  received word.
- channel  output  1  channel of `data`: 0 = left, 1 = right.
- valid  output  1  `data`/`channel` hold an unconsumed word.
- ready  input  1  consumer accepts the word when `valid & ready`.
- overflow  output  1  sticky: a completed word was dropped.
- clear_ovf  input  1  synchronous clear of `overflow`.

## Operation
- `sck`, `ws` and `sd` each pass through SYNC_STAGES flops. One extra `sck` flop gives `rise = sck_s & ~sck_d`. All actions below happen only on `rise` cycles, using synchronised `ws_s` and `sd_s`.
- `ws_prev` holds `ws_s` from the previous rise. A transition is `ws_s != ws_prev`.
- Per I2S, the bit sampled on the rise where the transition is seen is the last bit of the old word. The MSB of the new word arrives on the next rise.
- FSM:
  - PRIME (reset state): on the first rise, load `ws_prev`, go to SYNC. No transition is evaluated.
  - SYNC: on a rise with a transition, clear the shift register, set `cnt = 0`, latch `cur_ch = ws_s`, go to RUN. The partial word is discarded.
  - RUN, rise without a transition: if `cnt < WIDTH`, write `sd_s` into bit `WIDTH-1-cnt` and increment `cnt`. Otherwise ignore the bit; `cnt` saturates at WIDTH.
  - RUN, rise with a transition: insert `sd_s` at bit `WIDTH-1-cnt` if `cnt < WIDTH`, then complete the word with channel `cur_ch`. Then clear the shift register, set `cnt = 0`, `cur_ch = ws_s`, and stay in RUN.
- Width rules:
  - Slots longer than WIDTH keep the MSBs; extra LSBs are dropped.
  - Shorter slots are left-justified and zero-padded in the LSBs.
  - A zero-bit slot (transitions on consecutive rises) still completes a word.
- Holding register on word completion:
  - If `valid == 0`, or `valid & ready` in the same cycle: load `data`/`channel`, `valid = 1`.
  - Otherwise: keep the old word, drop the new one, set `overflow = 1`.
- `valid & ready` with no completion: `valid` → 0 next edge; `data` is retained.
- `overflow` clears on `clear_ovf`. A simultaneous set and clear leaves `overflow = 1`.

## Timing
- Reset values: `data = 0`, `channel = 0`, `valid = 0`, `overflow = 0`, FSM = PRIME, all synchroniser flops, `ws_prev`, `cnt`, shift register and `cur_ch` = 0.
- Reset mid-word: all outputs drop on `rst` assertion without waiting for `clk`. The partial word is lost. After release, one rise (PRIME) plus one `ws` transition (SYNC) are needed before the next word is captured.
- Latency: call the first `clk` edge that samples the `sck` pin high (closing the transition slot) edge 0. `rise` is asserted after edge SYNC_STAGES−1, and `valid` goes high after edge SYNC_STAGES.
- `ws` and `sd` take the same synchroniser path as `sck`, so they are sampled with identical delay.
- `valid` and `data` are registered outputs with no combinational path from `ready`. A word is consumed on the `clk` edge where `valid & ready`.
- Steady-state throughput is one word per slot. With `ready` held at 1, overflow never occurs.

## Test plan
- Reset, then left slot 0xA5C3 and right slot 0x1234 (WIDTH=16, 16-bit slots, `ready = 1`) after a sync transition → `valid` pulses for 1 cycle twice: (0xA5C3, ch 0), then (0x1234, ch 1). `overflow` stays 0.
- Release reset mid right slot → that partial slot and the PRIME rise produce no `valid`. First output is the next full left word.
- 24-bit slot carrying 0xABCDEF → `data = 0xABCD`. An 8-bit slot carrying 0x5A → `data = 0x5A00`.
- `ready = 0` across words 0x1111 (left) and 0x2222 (right) → `data` holds 0x1111 and `overflow = 1` after the second completion. With `ready = 1` → 0x1111 is consumed and `valid = 0`. Pulse `clear_ovf` → `overflow = 0`. Set and clear in the same cycle → `overflow` stays 1.
- Assert `rst` after 7 bits of a word while `valid = 1` → `valid`, `data` and `overflow` are 0 immediately. After release, no output appears until PRIME, SYNC and a full slot have passed.
- Measure latency: the slot-closing `sck` rise with SYNC_STAGES=2 → `valid` is high after the 3rd `clk` edge counting from the first edge that samples `sck` high.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S stereo receiver: synchronises sck/ws/sd into clk, deserialises MSB-first slots
// into WIDTH-bit words and hands them out through a ready/valid holding register.
module i2s_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             ws,
    input  logic             sd,
    output logic [WIDTH-1:0] data,
    output logic             channel,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] ws_sync_reg;
    logic [SYNC_STAGES-1:0] sd_sync_reg;
    logic                   sck_d_reg;
    logic                   sck_s;
    logic                   ws_s;
    logic                   sd_s;
    logic                   rise;

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       shift_reg, shift_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   cur_ch_reg, cur_ch_next;
    logic                   ws_prev_reg, ws_prev_next;

    logic                   transition;
    logic                   in_range;
    logic [WIDTH-1:0]       bit_mask;
    logic                   word_done;
    logic [WIDTH-1:0]       word_data;

    logic [WIDTH-1:0]       data_reg;
    logic                   channel_reg;
    logic                   valid_reg;
    logic                   overflow_reg;

    // All three pins share one synchroniser depth so ws/sd stay aligned with sck.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_reg <= '0;
            ws_sync_reg  <= '0;
            sd_sync_reg  <= '0;
            sck_d_reg    <= 1'b0;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            ws_sync_reg  <= {ws_sync_reg[SYNC_STAGES-2:0], ws};
            sd_sync_reg  <= {sd_sync_reg[SYNC_STAGES-2:0], sd};
            sck_d_reg    <= sck_s;
        end
    end

    assign sck_s = sck_sync_reg[SYNC_STAGES-1];
    assign ws_s  = ws_sync_reg[SYNC_STAGES-1];
    assign sd_s  = sd_sync_reg[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= PRIME;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            cur_ch_reg  <= 1'b0;
            ws_prev_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            cur_ch_reg  <= cur_ch_next;
            ws_prev_reg <= ws_prev_next;
        end
    end

    assign transition = ws_s ^ ws_prev_reg;
    assign in_range   = (cnt_reg < CW'(WIDTH));
    assign bit_mask   = {{(WIDTH-1){1'b0}}, sd_s} << (CW'(WIDTH - 1) - cnt_reg);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        cur_ch_next  = cur_ch_reg;
        ws_prev_next = ws_prev_reg;
        word_done    = 1'b0;
        word_data    = in_range ? (shift_reg | bit_mask) : shift_reg;
        if (rise) begin
            ws_prev_next = ws_s;
            case (state_reg)
                PRIME: state_next = SYNC;
                SYNC: begin
                    if (transition) begin
                        shift_next  = '0;
                        cnt_next    = '0;
                        cur_ch_next = ws_s;
                        state_next  = RUN;
                    end
                end
                RUN: begin
                    // The bit seen with a ws change is the last bit of the closing word.
                    if (transition) begin
                        word_done   = 1'b1;
                        shift_next  = '0;
                        cnt_next    = '0;
                        cur_ch_next = ws_s;
                    end else if (in_range) begin
                        shift_next = word_data;
                        cnt_next   = cnt_reg + CW'(1);
                    end
                end
                default: state_next = PRIME;
            endcase
        end
    end

    // A new word may replace the held one in the same cycle it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg     <= '0;
            channel_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (word_done && (!valid_reg || ready)) begin
                data_reg    <= word_data;
                channel_reg <= cur_ch_reg;
                valid_reg   <= 1'b1;
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
            if (word_done && valid_reg && !ready) begin
                overflow_reg <= 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign data     = data_reg;
    assign channel  = channel_reg;
    assign valid    = valid_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives I2S slots bit by bit and checks received words
// against a slot-level model of left-justified truncation/padding.
module tb_i2s_receiver;

    localparam int WIDTH = 16;
    localparam int SS    = 2;

    logic             clk;
    logic             rst;
    logic             sck;
    logic             ws;
    logic             sd;
    logic [WIDTH-1:0] data;
    logic             channel;
    logic             valid;
    logic             ready;
    logic             overflow;
    logic             clear_ovf;

    int               checks = 0;
    int               errors = 0;
    logic             cur_ws;
    logic [16:0]      exp_q[$];
    logic [16:0]      mon_e;

    i2s_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ws        (ws),
        .sd        (sd),
        .data      (data),
        .channel   (channel),
        .valid     (valid),
        .ready     (ready),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Keep the first WIDTH bits of the slot, MSB-aligned; pad short slots with zeros.
    function automatic logic [15:0] model_word(input logic [31:0] val, input int len);
        longint unsigned v;
        v = 64'(val) & ((64'd1 << len) - 64'd1);
        if (len >= 16) return 16'(v >> (len - 16));
        else           return 16'(v << (16 - len));
    endfunction

    task automatic bit_period(input logic w, input logic d, input int half,
                              input bit measure, input bit clr);
        bit seen;
        seen = 1'b0;
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (half) @(negedge clk);
        sck = 1'b1;
        for (int k = 1; k <= half; k++) begin
            @(posedge clk);
            #1;
            if (measure && !seen && valid) begin
                seen = 1'b1;
                chk("latency_edges", 32'(k), 32'(SS + 1));
            end
            if (clr && k == 2) clear_ovf = 1'b1;
            if (clr && k == 3) begin
                clear_ovf = 1'b0;
                chk("ovf_set_and_clear", 32'(overflow), 32'd1);
            end
        end
        if (measure) chk("latency_seen", 32'(seen), 32'd1);
        @(negedge clk);
        sck = 1'b0;
    endtask

    // One slot of channel cur_ws; ws flips on its last bit as I2S requires.
    task automatic send_slot(input logic [31:0] val, input int len, input bit expect_word,
                             input int half, input bit measure, input bit clr);
        logic ch;
        ch = cur_ws;
        if (expect_word) exp_q.push_back({ch, model_word(val, len)});
        for (int i = len - 1; i >= 0; i--)
            bit_period((i == 0) ? ~ch : ch, val[i], half, measure && (i == 0), clr && (i == 0));
        cur_ws = ~ch;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                $display("word ch=%0d data=%h expected ch=%0d data=%h",
                         channel, data, mon_e[16], mon_e[15:0]);
                chk("data", 32'(data), 32'(mon_e[15:0]));
                chk("channel", 32'(channel), 32'(mon_e[16]));
            end
        end
    end

    initial begin
        rst = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        ready = 1'b1; clear_ovf = 1'b0; cur_ws = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_channel", 32'(channel), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Preamble: PRIME rise plus a right->left transition; yields no word.
        send_slot($urandom, 5, 1'b0, 4, 1'b0, 1'b0);
        send_slot(32'hA5C3, 16, 1'b1, 4, 1'b0, 1'b0);
        send_slot(32'h1234, 16, 1'b1, 4, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        chk("basic_drained", 32'(exp_q.size()), 32'd0);
        chk("basic_overflow", 32'(overflow), 32'd0);

        send_slot(32'hABCDEF, 24, 1'b1, 4, 1'b0, 1'b0);
        send_slot(32'h5A, 8, 1'b1, 4, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("width_drained", 32'(exp_q.size()), 32'd0);

        for (int n = 0; n < 16; n++)
            send_slot($urandom, int'($urandom_range(1, 32)), 1'b1,
                      int'($urandom_range(2, 4)), 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_overflow", 32'(overflow), 32'd0);

        // Backpressure: second word is dropped and flagged.
        ready = 1'b0;
        send_slot(32'h1111, 16, 1'b1, 4, 1'b0, 1'b0);
        send_slot(32'h2222, 16, 1'b0, 4, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_data", 32'(data), 32'h1111);
        chk("bp_channel", 32'(channel), 32'd0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1;
        chk("consumed_valid", 32'(valid), 32'd0);
        chk("consumed_data_kept", 32'(data), 32'h1111);
        ready = 1'b0;
        @(posedge clk); #1 clear_ovf = 1'b1;
        @(posedge clk); #1 clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        @(negedge clk);

        send_slot(32'h3333, 16, 1'b1, 4, 1'b0, 1'b0);
        send_slot(32'h4444, 16, 1'b0, 4, 1'b0, 1'b1);
        send_slot($urandom, 16, 1'b0, 4, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        chk("pre_rst_data", 32'(data), 32'h3333);

        // Reset seven bits into a right slot, asynchronously to clk.
        for (int i = 0; i < 7; i++) bit_period(1'b1, 1'($urandom_range(0, 1)), 4, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_channel", 32'(channel), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_slot($urandom, 9, 1'b0, 4, 1'b0, 1'b0);
        send_slot(32'hBEEF, 16, 1'b1, 4, 1'b0, 1'b0);
        send_slot(32'hCAFE, 16, 1'b1, 3, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);
        chk("post_rst_overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
